// File: rtl/delay_arb_pkg.sv
// Shared types and defaults for the round-robin delay arbiter.
package delay_arb_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } state_t;

  // Pointer width that stays legal even for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_arb_ctrl_rr_pick.sv
// Combinational round-robin picker: first active request at or after rr_ptr, wrapping.
module rr_pick
  import delay_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int PTR_W   = ptr_width(DEFAULT_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_arb_ctrl.sv
// Shares one programmable delay counter among NUM_REQ requesters, granted round-robin,
// and strobes pulse_out/done on the owner when its delay expires.
module delay_arb_ctrl
  import delay_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] cfg_delay,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       pulse_out,
  output logic                     done,
  output logic                     busy
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_next;
  logic [NUM_REQ-1:0] grant_next, pulse_next;
  logic               done_next, busy_next;

  logic [NUM_REQ-1:0] pick_winner;
  logic               pick_valid;
  logic [PTR_W-1:0]   win_idx;
  logic [CNT_W-1:0]   win_delay;
  logic               owner_live;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_rr_pick (
    .req   (req),
    .rr_ptr(rr_ptr),
    .winner(pick_winner),
    .valid (pick_valid)
  );

  // Index and delay of the one-hot winner; cfg_delay is only looked at here.
  always_comb begin
    win_idx   = '0;
    win_delay = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_winner[i]) begin
        win_idx   = PTR_W'(i);
        win_delay = cfg_delay[i*CNT_W +: CNT_W];
      end
    end
  end

  assign owner_live = |(req & grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      grant     <= '0;
      pulse_out <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_next;
      rr_ptr    <= rr_ptr_next;
      grant     <= grant_next;
      pulse_out <= pulse_next;
      done      <= done_next;
      busy      <= busy_next;
    end
  end

  // A dropped owner request aborts the count even on the cycle it would have fired.
  always_comb begin
    next_state  = state;
    cnt_next    = cnt;
    rr_ptr_next = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          next_state  = COUNT;
          cnt_next    = win_delay;
          rr_ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
      end
      COUNT: begin
        if (!owner_live) begin
          next_state = IDLE;
        end else if (cnt == '0) begin
          next_state = FIRE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      FIRE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    grant_next = grant;
    pulse_next = '0;
    done_next  = 1'b0;
    busy_next  = (next_state != IDLE);
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_next = pick_winner;
        end
      end
      COUNT: begin
        if (next_state == IDLE) begin
          grant_next = '0;
        end else if (next_state == FIRE) begin
          pulse_next = grant;
          done_next  = 1'b1;
        end
      end
      FIRE: begin
        grant_next = '0;
      end
      default: begin
        grant_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_delay_arb_ctrl.sv
// Scoreboard bench for delay_arb_ctrl: a transaction-level model predicts grants and
// pulse deadlines, and a negedge monitor checks the DUT against them.
module tb_delay_arb_ctrl;
  import delay_arb_pkg::*;

  localparam int NUM_REQ = DEFAULT_NUM_REQ;
  localparam int CNT_W   = DEFAULT_CNT_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] cfg_delay;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       pulse_out;
  logic                     done;
  logic                     busy;

  always #5 clk = ~clk;

  delay_arb_ctrl #(
    .NUM_REQ(NUM_REQ),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .cfg_delay(cfg_delay),
    .grant    (grant),
    .pulse_out(pulse_out),
    .done     (done),
    .busy     (busy)
  );

  typedef struct {
    int ch;
    int cyc;
  } pulse_t;

  pulse_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  int cyc      = 0;
  int owner    = -1;
  int deadline = 0;
  int ptr      = 0;
  int pick_idx;
  bit pick_found;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, got, exp, cyc);
    end
  endtask

  // Model: a grant at edge E with delay D promises a pulse at edge E+D+1 unless the
  // owner drops its request or reset arrives first; the counter frees the edge after.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      if (owner >= 0 && cyc <= deadline && exp_q.size() > 0) void'(exp_q.pop_back());
      owner = -1;
      ptr   = 0;
    end else if (owner < 0) begin
      pick_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        pick_idx = (ptr + k) % NUM_REQ;
        if (!pick_found && req[pick_idx]) begin
          pick_found = 1'b1;
          owner      = pick_idx;
        end
      end
      if (pick_found) begin
        deadline = cyc + int'(cfg_delay[owner*CNT_W +: CNT_W]) + 1;
        ptr      = (owner + 1) % NUM_REQ;
        exp_q.push_back('{ch: owner, cyc: deadline});
      end
    end else if (cyc <= deadline) begin
      if (!req[owner]) begin
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        owner = -1;
      end
    end else begin
      owner = -1;
    end
  end

  logic [NUM_REQ-1:0] exp_grant;
  pulse_t             got_p;

  always @(negedge clk) begin
    exp_grant = (owner >= 0) ? (NUM_REQ'(1) << owner) : '0;
    check_output("grant", 32'(grant), 32'(exp_grant));
    check_output("busy", 32'(busy), 32'(owner >= 0));
    check_output("done_vs_pulse", 32'(done), 32'(pulse_out != '0));
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL missed_pulse: got none expected ch %0d at edge %0d", exp_q[0].ch, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (pulse_out != '0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL spurious_pulse: got %0h expected none at edge %0d", pulse_out, cyc);
      end else begin
        got_p = exp_q.pop_front();
        check_output("pulse_ch", 32'(pulse_out), 32'(NUM_REQ'(1) << got_p.ch));
        check_output("pulse_edge", 32'(cyc), 32'(got_p.cyc));
      end
    end
  end

  task automatic apply_stimulus(input logic [NUM_REQ-1:0] r, input int ch, input int d);
    @(negedge clk);
    req = r;
    if (ch >= 0) cfg_delay[ch*CNT_W +: CNT_W] = CNT_W'(d);
  endtask

  task automatic wait_done(input int bound, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      seen = (done === 1'b1);
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL %s_timeout: got no done expected done within %0d cycles", name, bound);
    end
  endtask

  task automatic wait_grant(input int bound, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      seen = (grant !== '0 && !$isunknown(grant));
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL %s_timeout: got no grant expected grant within %0d cycles", name, bound);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req       = '0;
    cfg_delay = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single request, delay 3");
    apply_stimulus(4'b0001, 0, 3);
    wait_done(20, "single");
    req = '0;
    repeat (3) @(negedge clk);

    $display("[TB] zero delay");
    apply_stimulus(4'b0010, 1, 0);
    wait_done(10, "zero");
    req = '0;
    repeat (3) @(negedge clk);

    $display("[TB] round-robin with all requests held");
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) cfg_delay[i*CNT_W +: CNT_W] = CNT_W'(1);
    apply_stimulus(4'b1111, -1, 0);
    for (int n = 0; n < 5; n++) wait_done(20, "round_robin");
    req = '0;
    repeat (3) @(negedge clk);

    $display("[TB] abort by dropping request");
    apply_stimulus(4'b0100, 2, 10);
    wait_grant(10, "abort");
    repeat (4) @(negedge clk);
    req = '0;
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) cfg_delay[i*CNT_W +: CNT_W] = '0;
    apply_stimulus(4'b1111, -1, 0);
    wait_done(10, "after_abort");
    req = '0;
    repeat (3) @(negedge clk);

    $display("[TB] reset mid-count");
    apply_stimulus(4'b0001, 0, 20);
    wait_grant(10, "reset_mid");
    repeat (11) @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] config change during count");
    apply_stimulus(4'b1000, 3, 5);
    wait_grant(10, "cfg_change");
    @(negedge clk);
    cfg_delay[3*CNT_W +: CNT_W] = CNT_W'(1);
    wait_done(20, "cfg_change");
    req = '0;
    repeat (3) @(negedge clk);

    $display("[TB] maximum delay");
    apply_stimulus(4'b0001, 0, (1 << CNT_W) - 1);
    wait_done((1 << CNT_W) + 10, "max_delay");
    req = '0;
    repeat (3) @(negedge clk);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) req = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 7) == 0)
          cfg_delay[i*CNT_W +: CNT_W] = ($urandom_range(0, 31) == 0) ? CNT_W'(40) : CNT_W'($urandom_range(0, 6));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (5) @(negedge clk);
    check_output("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
